uart_frame_loader: RTL
======================

// Module: uart_frame_loader
// PURPOSE
//  Consumes the byte stream from the UART receiver (rx_dv/rx_byte) and parses framed image uploads:
//  SYNC byte, N_PIXELS payload bytes, 8-bit checksum. Writes each payload byte to the image buffer
//  write port, then pulses frame_done to start inference, or frame_err with a cause code.
//  Sits between uart_rx and the CNN input buffer.
// PARAMETERS
//  IMG_W         28                           image width in pixels
//  IMG_H         28                           image height in pixels
//  N_PIXELS      IMG_W*IMG_H                  payload bytes per frame
//  ADDR_W        $clog2(N_PIXELS)             buffer address width
//  SYNC_BYTE     8'hA5                        frame start marker
//  CLK_FREQ      50_000_000                   system clock in Hz
//  BAUD          115200                       line rate
//  CLKS_PER_BIT  CLK_FREQ/BAUD                clocks per UART bit
//  TIMEOUT_CLKS  CLKS_PER_BIT*10*16           inter-byte gap limit (16 byte times)
// PORTS
//  clk        in   1       system clock
//  reset      in   1       asynchronous, active-high reset
//  rx_dv      in   1       one-cycle pulse: rx_byte valid
//  rx_byte    in   8       received byte
//  inf_busy   in   1       inference running; new frames are refused
//  mem_we     out  1       buffer write strobe
//  mem_addr   out  ADDR_W  buffer write address
//  mem_wdata  out  8       buffer write data
//  busy       out  1       frame in progress (SYNC accepted, not yet done/err)
//  frame_done out  1       one-cycle pulse: frame complete, checksum good
//  frame_err  out  1       one-cycle pulse: frame rejected
//  err_code   out  2       0 NONE, 1 CSUM, 2 TIMEOUT, 3 BUSY. Held until next done/err.
// BEHAVIOUR
//  Interface: one clock domain (clk). reset is asynchronous and active-high.
//  - Reset: all outputs 0, err_code NONE, state IDLE. Async assert takes effect mid-frame with no
//    further writes. Buffer contents are not cleared.
//  - All outputs are registered. Each output responds one cycle after the rx_dv that causes it.
//  - FSM:
//    - IDLE: non-SYNC bytes are ignored silently.
//      - SYNC with inf_busy=1: frame_err, code BUSY, stay in IDLE.
//      - SYNC with inf_busy=0: busy<=1, addr cnt<=0, csum<=0, go to PAYLOAD.
//    - PAYLOAD: each rx_dv gives mem_we=1, mem_addr=cnt, mem_wdata=rx_byte, csum+=rx_byte
//      (mod 256), cnt++.
//      - The byte at cnt==N_PIXELS-1 moves the FSM to CHECK.
//      - A SYNC value inside the payload is plain data (no escaping).
//    - CHECK: next rx_dv is compared against csum.
//      - Equal: frame_done, err_code NONE.
//      - Not equal: frame_err, code CSUM. No mem_we for the checksum byte.
//      - Either way: busy<=0, back to IDLE.
//  - Gap timer runs only in PAYLOAD/CHECK. It clears on every rx_dv.
//    - On reaching TIMEOUT_CLKS-1 without rx_dv: frame_err, code TIMEOUT, busy<=0, IDLE.
//    - If rx_dv and expiry fall on the same cycle, the byte wins and the timer clears.
//  - inf_busy is sampled only at SYNC. Asserting it mid-frame does not abort the frame.
//  - mem_addr never exceeds N_PIXELS-1. cnt returns to 0 on the next accepted SYNC.
//  - frame_done and frame_err are never high together. At most one pulse per frame.
// STRUCTURE
//  - uart_frame_pkg holds:
//    - err_t enum (ERR_NONE/CSUM/TIMEOUT/BUSY)
//    - state_t enum (IDLE/PAYLOAD/CHECK)
//    - DEFAULT_SYNC_BYTE = 8'hA5
//  - Sub-module gap_timer (params LIMIT; ports clk, reset, en, clr, expired) holds the timeout counter.
//  - FSM, address counter and checksum accumulator stay in this module.
// TESTING
//  - Good frame: A5, bytes i%256 for i=0..783, csum 8'hF8
//    -> 784 mem_we, addr 0..783 in order, data matches, one frame_done, err_code 0, busy low after.
//  - Same frame with csum 8'hF9 -> one frame_err, err_code 1, no frame_done, busy low.
//  - A5 then 100 bytes, then line silent
//    -> frame_err, code 2, exactly TIMEOUT_CLKS cycles after last rx_dv.
//    -> Next good frame starts at addr 0 and passes.
//  - inf_busy=1, A5 then 784 x 8'h00 -> frame_err code 3 once, zero mem_we, busy stays 0.
//  - 8'h00, 8'hFF before A5 are ignored. Payload byte 8'hA5 at index 5 is written to addr 5.
//    Frame with matching csum -> frame_done.
//  - reset pulsed after payload byte 400 -> all outputs 0 the same cycle, no further mem_we.
//    Following good frame completes normally.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART image frame loader.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_CSUM    = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_BUSY    = 2'd3
  } err_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_frame_loader_gap_timer.sv
// Inter-byte gap counter: counts while enabled, clears on clr or when disabled,
// and saturates at LIMIT-1 where it flags expiry.
module gap_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr || !en) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = en && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/uart_frame_loader.sv
// Parses SYNC / payload / checksum frames from the UART byte stream, writes the
// payload into the image buffer and reports completion or a rejection cause.
module uart_frame_loader
  import uart_frame_pkg::*;
#(
  parameter int         IMG_W        = 28,
  parameter int         IMG_H        = 28,
  parameter int         N_PIXELS     = IMG_W * IMG_H,
  parameter int         ADDR_W       = $clog2(N_PIXELS),
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
  parameter int         CLK_FREQ     = 50_000_000,
  parameter int         BAUD         = 115200,
  parameter int         CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter int         TIMEOUT_CLKS = CLKS_PER_BIT * 10 * 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_dv,
  input  logic [7:0]        rx_byte,
  input  logic              inf_busy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err,
  output logic [1:0]        err_code
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIXELS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [7:0]        csum_q, csum_d;
  logic              we_d, busy_d, done_d, err_d;
  logic [ADDR_W-1:0] addr_d;
  logic [7:0]        wdata_d;
  err_t              code_q, code_d;
  logic              expired;

  gap_timer #(
    .LIMIT (TIMEOUT_CLKS)
  ) u_gap_timer (
    .clk     (clk),
    .reset   (reset),
    .en      (state_q != IDLE),
    .clr     (rx_dv),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    busy_d  = busy;
    done_d  = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;

    case (state_q)
      IDLE: begin
        if (rx_dv && (rx_byte == SYNC_BYTE)) begin
          if (inf_busy) begin
            err_d  = 1'b1;
            code_d = ERR_BUSY;
          end else begin
            busy_d  = 1'b1;
            cnt_d   = '0;
            csum_d  = '0;
            state_d = PAYLOAD;
          end
        end
      end

      // A received byte always takes priority over a simultaneous timer expiry.
      PAYLOAD: begin
        if (rx_dv) begin
          we_d    = 1'b1;
          addr_d  = cnt_q;
          wdata_d = rx_byte;
          csum_d  = csum_q + rx_byte;
          if (cnt_q == LAST_ADDR) begin
            state_d = CHECK;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end else if (expired) begin
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      CHECK: begin
        if (rx_dv) begin
          busy_d  = 1'b0;
          state_d = IDLE;
          if (rx_byte == csum_q) begin
            done_d = 1'b1;
            code_d = ERR_NONE;
          end else begin
            err_d  = 1'b1;
            code_d = ERR_CSUM;
          end
        end else if (expired) begin
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      csum_q     <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      code_q     <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      csum_q     <= csum_d;
      mem_we     <= we_d;
      mem_addr   <= addr_d;
      mem_wdata  <= wdata_d;
      busy       <= busy_d;
      frame_done <= done_d;
      frame_err  <= err_d;
      code_q     <= code_d;
    end
  end

  assign err_code = code_q;

endmodule
